// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift sequencer: op codes, amount-source codes,
// FSM states and the per-cycle shift class.
package shift_seq_pkg;

    localparam int unsigned SL16_AMT = 16;

    typedef enum logic [2:0] {
        OP_SLL     = 3'b000,
        OP_SRL     = 3'b001,
        OP_SRA     = 3'b010,
        OP_SLLV    = 3'b011,
        OP_SRLV    = 3'b100,
        OP_SRAV    = 3'b101,
        OP_SL16    = 3'b110,
        OP_ILLEGAL = 3'b111
    } op_e;

    localparam logic [2:0] AMT_SEL_SHAMT = 3'b000;
    localparam logic [2:0] AMT_SEL_REG   = 3'b010;
    localparam logic [2:0] AMT_SEL_CONST = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        SH_LEFT = 2'b00,
        SH_SRL  = 2'b01,
        SH_SRA  = 2'b10
    } shift_class_e;

    // Direction and fill rule implied by an op; illegal ops never shift.
    function automatic shift_class_e op_class(input op_e op);
        case (op)
            OP_SRL, OP_SRLV: op_class = SH_SRL;
            OP_SRA, OP_SRAV: op_class = SH_SRA;
            default:         op_class = SH_LEFT;
        endcase
    endfunction

endpackage

// File: rtl/shift_sequencer_step.sv
// One-bit shift of the working register, direction and fill chosen by class.
module shift_step
    import shift_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] data,
    input  shift_class_e      cls,
    output logic [DATA_W-1:0] shifted_c
);

    always_comb begin
        shifted_c = data;
        case (cls)
            SH_LEFT: shifted_c = {data[DATA_W-2:0], 1'b0};
            SH_SRL:  shifted_c = {1'b0, data[DATA_W-1:1]};
            SH_SRA:  shifted_c = {data[DATA_W-1], data[DATA_W-1:1]};
            default: shifted_c = data;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle barrel-less shifter: captures an operand on start, shifts one
// bit per cycle until the amount is exhausted, then pulses done.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned AMT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [AMT_W-1:0]  shamt,
    input  logic [DATA_W-1:0] rs_value,
    input  logic [DATA_W-1:0] rt_value,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [2:0]        amt_sel,
    output logic              illegal
);

    state_e            state;
    logic [AMT_W-1:0]  count;
    shift_class_e      cls;
    logic [DATA_W-1:0] step_c;

    logic [AMT_W-1:0]  req_amt_c;
    logic [2:0]        req_sel_c;
    logic              req_illegal_c;
    shift_class_e      req_cls_c;

    // Only the low amount bits of the register operand matter.
    logic unused_rs_hi;
    assign unused_rs_hi = ^rs_value[DATA_W-1:AMT_W];

    // Amount source decode for the request presented this cycle.
    always_comb begin
        req_amt_c     = '0;
        req_sel_c     = AMT_SEL_SHAMT;
        req_illegal_c = 1'b0;
        req_cls_c     = op_class(op_e'(op));
        case (op_e'(op))
            OP_SLL, OP_SRL, OP_SRA: req_amt_c = shamt;
            OP_SLLV, OP_SRLV, OP_SRAV: begin
                req_amt_c = rs_value[AMT_W-1:0];
                req_sel_c = AMT_SEL_REG;
            end
            OP_SL16: begin
                req_amt_c = AMT_W'(SL16_AMT);
                req_sel_c = AMT_SEL_CONST;
            end
            default: req_illegal_c = 1'b1;
        endcase
    end

    shift_step #(.DATA_W(DATA_W)) u_step (
        .data      (result),
        .cls       (cls),
        .shifted_c (step_c)
    );

    // result doubles as the working shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            result  <= '0;
            count   <= '0;
            cls     <= SH_LEFT;
            amt_sel <= AMT_SEL_SHAMT;
            busy    <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        result  <= rt_value;
                        count   <= req_amt_c;
                        cls     <= req_cls_c;
                        amt_sel <= req_sel_c;
                        busy    <= 1'b1;
                        if (req_illegal_c || (req_amt_c == '0)) begin
                            state   <= ST_DONE;
                            done    <= 1'b1;
                            illegal <= req_illegal_c;
                        end else begin
                            state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    result <= step_c;
                    count  <= count - AMT_W'(1);
                    if (count == AMT_W'(1)) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench: directed vector table, random ops against a plain
// arithmetic model, and hand-written sequences for dropped starts and reset abort.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [4:0]  shamt;
    logic [31:0] rs_value;
    logic [31:0] rt_value;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [2:0]  amt_sel;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    shift_sequencer #(.DATA_W(32), .AMT_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .shamt    (shamt),
        .rs_value (rs_value),
        .rt_value (rt_value),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .amt_sel  (amt_sel),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  shamt;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] res;
        logic [2:0]  sel;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: amount from op rules, then whole-word shift.
    task automatic model(input logic [2:0] m_op, input logic [4:0] m_shamt,
                         input logic [31:0] m_rs, input logic [31:0] m_rt,
                         output logic [31:0] m_res, output logic [2:0] m_sel,
                         output logic m_ill, output int m_lat);
        int amt;
        m_ill = 1'b0;
        m_sel = 3'b000;
        if (m_op <= 3'd2) amt = int'(m_shamt);
        else if (m_op <= 3'd5) begin amt = int'(m_rs % 32); m_sel = 3'b010; end
        else if (m_op == 3'd6) begin amt = 16; m_sel = 3'b100; end
        else begin amt = 0; m_ill = 1'b1; end
        case (m_op)
            3'd0, 3'd3, 3'd6: m_res = m_rt << amt;
            3'd1, 3'd4:       m_res = m_rt >> amt;
            3'd2, 3'd5:       m_res = 32'($signed(m_rt) >>> amt);
            default:          m_res = m_rt;
        endcase
        m_lat = amt + 1;
    endtask

    // Called at a negedge in IDLE; presents one start, then scrambles inputs.
    task automatic issue(input string name, input logic [2:0] i_op, input logic [4:0] i_shamt,
                         input logic [31:0] i_rs, input logic [31:0] i_rt);
        @(negedge clk);
        check({name, " idle_busy"}, 32'(busy), 32'd0);
        check({name, " idle_done"}, 32'(done), 32'd0);
        start = 1'b1; op = i_op; shamt = i_shamt; rs_value = i_rs; rt_value = i_rt;
        @(negedge clk);
        start = 1'b0;
        op = 3'($urandom); shamt = 5'($urandom); rs_value = $urandom; rt_value = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 64) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run(input string name, input vec_t v);
        int lat;
        issue(name, v.op, v.shamt, v.rs, v.rt);
        wait_done(lat);
        check({name, " latency"}, 32'(lat), 32'(v.lat));
        check({name, " result"}, result, v.res);
        check({name, " amt_sel"}, 32'(amt_sel), 32'(v.sel));
        check({name, " illegal"}, 32'(illegal), 32'(v.ill));
        check({name, " busy_at_done"}, 32'(busy), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int lat;
        int seen;

        vecs[0] = '{3'b000, 5'd4,  32'h0,        32'h00000001, 32'h00000010, 3'b000, 1'b0, 5};
        vecs[1] = '{3'b010, 5'd31, 32'h0,        32'h80000000, 32'hFFFFFFFF, 3'b000, 1'b0, 32};
        vecs[2] = '{3'b100, 5'd0,  32'h00000024, 32'hF0000000, 32'h0F000000, 3'b010, 1'b0, 5};
        vecs[3] = '{3'b110, 5'd3,  32'h0,        32'h00001234, 32'h12340000, 3'b100, 1'b0, 17};
        vecs[4] = '{3'b001, 5'd0,  32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 3'b000, 1'b0, 1};
        vecs[5] = '{3'b111, 5'd7,  32'h5,        32'hCAFEF00D, 32'hCAFEF00D, 3'b000, 1'b1, 1};
        vecs[6] = '{3'b101, 5'd9,  32'hFFFFFFE3, 32'h80000010, 32'hF0000002, 3'b010, 1'b0, 4};
        vecs[7] = '{3'b011, 5'd9,  32'hFFFFFFE0, 32'h12345678, 32'h12345678, 3'b010, 1'b0, 1};
        vecs[8] = '{3'b001, 5'd31, 32'h0,        32'h80000000, 32'h00000001, 3'b000, 1'b0, 32};
        vecs[9] = '{3'b000, 5'd1,  32'h0,        32'h80000001, 32'h00000002, 3'b000, 1'b0, 2};

        reset = 1'b1; start = 1'b0; op = '0; shamt = '0; rs_value = '0; rt_value = '0;
        @(negedge clk); @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        check("reset amt_sel", 32'(amt_sel), 32'd0);
        check("reset illegal", 32'(illegal), 32'd0);
        reset = 1'b0;

        // Directed table, issued back-to-back.
        for (int i = 0; i < 10; i++) run($sformatf("vec%0d", i), vecs[i]);

        // Random ops against the model.
        for (int i = 0; i < 40; i++) begin
            v.op = 3'($urandom); v.shamt = 5'($urandom); v.rs = $urandom; v.rt = $urandom;
            model(v.op, v.shamt, v.rs, v.rt, v.res, v.sel, v.ill, v.lat);
            run($sformatf("rand%0d op%0d", i, v.op), v);
        end

        // A second start during a 10-bit SLL is dropped.
        issue("drop", 3'b000, 5'd10, 32'h0, 32'h00000001);
        lat = 1;
        while (!done && lat < 64) begin
            start = (lat == 3);
            if (lat == 3) begin op = 3'b001; shamt = 5'd0; rt_value = 32'hFFFFFFFF; end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("drop latency", 32'(lat), 32'd11);
        check("drop result", result, 32'h00000400);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("drop no_second_done", 32'(seen), 32'd0);

        // Reset in the 3rd SHIFT cycle of an 8-bit SLL aborts the op.
        issue("abort", 3'b000, 5'd8, 32'h0, 32'h000000FF);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort result", result, 32'd0);
        check("abort done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("abort no_done", 32'(seen), 32'd0);

        // First start after reset is accepted.
        run("post_reset", vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
